// File: rtl/fixed_pkg.sv
// Shared Q4.28 fixed-point types and constants for the power-series datapath.
package fixed_pkg;

    localparam int unsigned W    = 32;
    localparam int unsigned FRAC = 28;

    typedef logic signed [W-1:0] q428_t;

    localparam q428_t ONE  = 32'sh1000_0000;
    localparam q428_t QMAX = 32'sh7FFF_FFFF;
    localparam q428_t QMIN = 32'sh8000_0000;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ostate_t;

endpackage

// File: rtl/fixed_series_dp_if.sv
// Controller/consumer bus of the series datapath: control strobes in, result port out.
interface fixed_series_dp_if;
    import fixed_pkg::*;

    q428_t x;
    q428_t cf;
    logic  m0;
    logic  m1;
    logic  resM1;
    logic  resM2;
    logic  resA1;
    logic  resA2;
    logic  resS;
    logic  st;
    q428_t y;
    logic  y_valid;
    logic  y_ready;
    logic  sat;
    logic  drop;

    modport master (
        output x, cf, m0, m1, resM1, resM2, resA1, resA2, resS, st, y_ready,
        input  y, y_valid, sat, drop
    );

    modport slave (
        input  x, cf, m0, m1, resM1, resM2, resA1, resA2, resS, st, y_ready,
        output y, y_valid, sat, drop
    );

endinterface

// File: rtl/fx_mul_q428.sv
// Combinational Q4.28 signed multiply: floor-truncated slice of the 64-bit product, saturated.
module fx_mul_q428
    import fixed_pkg::*;
(
    input  q428_t a,
    input  q428_t b,
    output q428_t prod,
    output logic  ovf
);

    localparam int unsigned PW  = 2 * W;
    localparam int unsigned TOP = W + FRAC - 1;

    logic signed [PW-1:0] p;

    // Result fits only when the bits above the slice are a pure sign extension.
    always_comb begin
        p    = PW'(a) * PW'(b);
        ovf  = (p[PW-1:TOP] != '0) && (p[PW-1:TOP] != '1);
        prod = ovf ? (p[PW-1] ? QMIN : QMAX) : W'(p >>> FRAC);
    end

endmodule

// File: rtl/fixed_series_dp.sv
// Power-series datapath: running power, term and saturating Q4.28 accumulator,
// with a one-entry valid/ready result register fed by rising edges of st.
module fixed_series_dp
    import fixed_pkg::*;
(
    input  logic               clk,
    input  logic               res,
    fixed_series_dp_if.slave   bus
);

    q428_t   pw;
    q428_t   tm;
    q428_t   sum;
    q428_t   pw_mul;
    q428_t   tm_mul;
    logic    pw_ovf;
    logic    tm_ovf;

    logic signed [W:0] add_full;
    q428_t   add_res;
    logic    add_ovf;
    logic    sat_set;

    ostate_t state_q;
    ostate_t state_d;
    logic    st_q;
    logic    cap;
    logic    load_y;
    logic    set_drop;
    q428_t   y_q;
    logic    sat_q;
    logic    drop_q;

    fx_mul_q428 u_mul_pw (.a(pw), .b(bus.x),  .prod(pw_mul), .ovf(pw_ovf));
    fx_mul_q428 u_mul_tm (.a(pw), .b(bus.cf), .prod(tm_mul), .ovf(tm_ovf));

    // Saturating accumulate; a saturation only counts when its result is written.
    always_comb begin
        add_full = (W+1)'(sum) + (W+1)'(tm);
        add_ovf  = add_full[W] ^ add_full[W-1];
        add_res  = add_ovf ? (add_full[W] ? QMIN : QMAX) : add_full[W-1:0];
        sat_set  = (bus.m0 & ~bus.resM1 & pw_ovf)
                 | (~bus.resM2 & tm_ovf)
                 | (bus.m1 & ~bus.resA1 & add_ovf);
    end

    always_ff @(posedge clk) begin
        if (res) begin
            pw  <= ONE;
            tm  <= '0;
            sum <= '0;
        end else begin
            pw  <= bus.resM1 ? ONE : (bus.m0 ? pw_mul : pw);
            tm  <= bus.resM2 ? '0 : tm_mul;
            sum <= bus.resA1 ? '0 : (bus.m1 ? add_res : sum);
        end
    end

    always_ff @(posedge clk) begin
        if (res)          sat_q <= 1'b0;
        else if (sat_set) sat_q <= 1'b1;
        else if (bus.resS) sat_q <= 1'b0;
    end

    assign cap = bus.st & ~st_q;

    always_ff @(posedge clk) begin
        if (res) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.resA2) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: if (cap)                 state_d = FULL;
                FULL:  if (bus.y_ready && !cap) state_d = EMPTY;
            endcase
        end
    end

    // A capture while FULL is only taken if the pending result leaves on the same edge.
    always_comb begin
        load_y   = 1'b0;
        set_drop = 1'b0;
        if (!bus.resA2 && cap) begin
            unique case (state_q)
                EMPTY: load_y = 1'b1;
                FULL: begin
                    load_y   = bus.y_ready;
                    set_drop = ~bus.y_ready;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            st_q   <= 1'b0;
            y_q    <= '0;
            drop_q <= 1'b0;
        end else begin
            st_q <= bus.st;
            if (bus.resA2) begin
                y_q    <= '0;
                drop_q <= 1'b0;
            end else begin
                if (load_y)   y_q    <= sum;
                if (set_drop) drop_q <= 1'b1;
            end
        end
    end

    assign bus.y       = y_q;
    assign bus.y_valid = (state_q == FULL);
    assign bus.sat     = sat_q;
    assign bus.drop    = drop_q;

endmodule
